servo_pulse_decoder: RTL and testbench

//  Receive end of the servo PWM interface: measures an incoming servo-style pulse train
//  (RC receiver or loop-back from the servo generator) and returns the duty word in

---
 rtl/servo_pkg.sv | 23 ++
 rtl/pwm_sync_edge.sv | 27 ++
 rtl/servo_pulse_decoder.sv | 151 +++++++++++++++
 tb/tb_servo_pulse_decoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo PWM definitions: FSM encoding, frame length and default timing limits.
// Used by the pulse generator, the pulse decoder and their benches.
package servo_pkg;

  localparam int unsigned FRAME_CLKS   = 2000001;
  localparam int unsigned DEF_CNT_W    = 32;
  localparam int unsigned DEF_TIMEOUT  = 2100000;
  localparam int unsigned DEF_MIN_HIGH = 50000;
  localparam int unsigned DEF_MAX_HIGH = 250000;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } servo_state_e;

  // One published measurement in generator format
  typedef struct packed {
    logic [DEF_CNT_W-1:0] duty;
    logic [DEF_CNT_W-1:0] period;
  } servo_meas_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous pulse pin plus an edge register
// producing single-cycle rise/fall indications.
module pwm_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pwm_i,
  output logic rise_c,
  output logic fall_c
);

  logic [1:0] sync_q;
  logic       edge_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pwm_i};
      edge_q <= sync_q[1];
    end
  end

  assign rise_c = sync_q[1] & ~edge_q;
  assign fall_c = ~sync_q[1] & edge_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures a servo-style pulse train and reports the high time in generator duty
// encoding (high time minus one) together with the rising-to-rising period.
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned MIN_HIGH = DEF_MIN_HIGH,
  parameter int unsigned MAX_HIGH = DEF_MAX_HIGH
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             out_of_range,
  output logic             signal_lost
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MIN_HIGH_C   = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_HIGH_C   = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE_C;
  endfunction

  logic rise_c, fall_c, edge_c, timeout_c, in_range_c;

  servo_state_e     state_q, state_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             oor_q, oor_d;
  logic             lost_q, lost_d;

  pwm_sync_edge u_sync (
    .clk_i  (clock_in),
    .rst_ni (reset_n),
    .pwm_i  (pwm_in),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  assign edge_c     = rise_c | fall_c;
  // An edge in the same cycle as the timeout keeps the signal alive
  assign timeout_c  = ~edge_c && (idle_cnt_q >= TIMEOUT_LAST);
  assign in_range_c = (hold_q >= MIN_HIGH_C) && (hold_q <= MAX_HIGH_C);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_RISE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout_c) begin
      state_d = WAIT_RISE;
    end else begin
      unique case (state_q)
        WAIT_RISE: if (rise_c) state_d = HIGH;
        HIGH:      if (fall_c) state_d = LOW;
        LOW:       if (rise_c) state_d = HIGH;
        default:   state_d = WAIT_RISE;
      endcase
    end
  end

  // Counters, hold register and publish logic
  always_comb begin
    high_cnt_d = high_cnt_q;
    per_cnt_d  = per_cnt_q;
    idle_cnt_d = edge_c ? '0 : sat_inc(idle_cnt_q);
    hold_d     = hold_q;
    duty_d     = duty_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    oor_d      = oor_q;
    lost_d     = lost_q;
    if (timeout_c) begin
      lost_d = 1'b1;
    end else begin
      unique case (state_q)
        WAIT_RISE: begin
          if (rise_c) begin
            high_cnt_d = ONE_C;
            per_cnt_d  = ONE_C;
            lost_d     = 1'b0;
          end
        end
        HIGH: begin
          per_cnt_d = sat_inc(per_cnt_q);
          if (fall_c) hold_d     = high_cnt_q;
          else        high_cnt_d = sat_inc(high_cnt_q);
        end
        LOW: begin
          if (rise_c) begin
            period_d   = per_cnt_q;
            oor_d      = ~in_range_c;
            high_cnt_d = ONE_C;
            per_cnt_d  = ONE_C;
            if (in_range_c) begin
              duty_d  = hold_q - ONE_C;
              valid_d = 1'b1;
            end
          end else begin
            per_cnt_d = sat_inc(per_cnt_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      high_cnt_q <= '0;
      per_cnt_q  <= '0;
      idle_cnt_q <= '0;
      hold_q     <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      oor_q      <= 1'b0;
      lost_q     <= 1'b1;
    end else begin
      high_cnt_q <= high_cnt_d;
      per_cnt_q  <= per_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      hold_q     <= hold_d;
      duty_q     <= duty_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      oor_q      <= oor_d;
      lost_q     <= lost_d;
    end
  end

  assign duty_out     = duty_q;
  assign period_out   = period_q;
  assign valid        = valid_q;
  assign out_of_range = oor_q;
  assign signal_lost  = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder with timing scaled down 1000x so whole frames fit in
// a short run; expected publishes are queued at each driven rise and matched on valid.
module tb_servo_pulse_decoder;
  import servo_pkg::*;

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned TIMEOUT  = 2100;
  localparam int unsigned MIN_HIGH = 50;
  localparam int unsigned MAX_HIGH = 250;
  localparam int unsigned FRAME    = 2001;

  logic             clock_in = 1'b0;
  logic             reset_n;
  logic             pwm_in;
  logic [CNT_W-1:0] duty_out;
  logic [CNT_W-1:0] period_out;
  logic             valid;
  logic             out_of_range;
  logic             signal_lost;

  always #5 clock_in = ~clock_in;

  servo_pulse_decoder #(
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .MIN_HIGH (MIN_HIGH),
    .MAX_HIGH (MAX_HIGH)
  ) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .pwm_in       (pwm_in),
    .duty_out     (duty_out),
    .period_out   (period_out),
    .valid        (valid),
    .out_of_range (out_of_range),
    .signal_lost  (signal_lost)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  servo_meas_t exp_q[$];

  // Reference model of the last completed frame and the published outputs
  bit          have_prev;
  int unsigned prev_h;
  int unsigned prev_p;
  logic [31:0] exp_duty;
  logic [31:0] exp_period;
  bit          exp_oor;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", tag, got, want, $time);
    end
  endtask

  always @(negedge clock_in) begin : sb_monitor
    servo_meas_t e;
    if (reset_n && valid) begin
      if (exp_q.size() == 0) begin
        chk("valid_unexpected", 32'(valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_duty", duty_out, e.duty);
        chk("sb_period", period_out, e.period);
        chk("sb_oor", 32'(out_of_range), 32'd0);
      end
    end
  end

  // Drive a rising edge, predict the publish it causes, check outputs, stay high h clocks
  task automatic rise_event(input int unsigned h);
    if (have_prev) begin
      exp_oor = (prev_h < MIN_HIGH) || (prev_h > MAX_HIGH);
      if (prev_p != 0) exp_period = prev_p;
      if (!exp_oor) begin
        exp_duty = prev_h - 1;
        exp_q.push_back('{duty: exp_duty, period: prev_p});
      end
    end
    pwm_in = 1'b1;
    repeat (5) @(negedge clock_in);
    chk("lost_after_rise", 32'(signal_lost), 32'd0);
    chk("duty_at_rise", duty_out, exp_duty);
    if (have_prev) chk("oor_at_rise", 32'(out_of_range), 32'(exp_oor));
    if (!have_prev || prev_p != 0) chk("period_at_rise", period_out, exp_period);
    repeat (h - 5) @(negedge clock_in);
  endtask

  task automatic send_frame(input int unsigned h, input int unsigned p);
    rise_event(h);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clock_in);
    have_prev = 1'b1;
    prev_h    = h;
    prev_p    = p;
  endtask

  initial begin
    reset_n    = 1'b0;
    pwm_in     = 1'b0;
    have_prev  = 1'b0;
    prev_h     = 0;
    prev_p     = 0;
    exp_duty   = '0;
    exp_period = '0;
    exp_oor    = 1'b0;
    repeat (3) @(negedge clock_in);
    chk("rst_duty", duty_out, 32'd0);
    chk("rst_period", period_out, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_oor", 32'(out_of_range), 32'd0);
    chk("rst_lost", 32'(signal_lost), 32'd1);
    reset_n = 1'b1;
    repeat (10) @(negedge clock_in);
    chk("lost_before_first", 32'(signal_lost), 32'd1);

    // Nominal frames, then a too-short pulse, then recovery
    for (int i = 0; i < 3; i++) send_frame(101, FRAME);
    send_frame(30, FRAME);
    send_frame(101, FRAME);
    send_frame(101, FRAME);

    // Input stuck low: loss must appear exactly TIMEOUT clocks after the synced fall
    rise_event(101);
    pwm_in = 1'b0;
    repeat (2 + TIMEOUT) @(negedge clock_in);
    chk("lost_one_early", 32'(signal_lost), 32'd0);
    @(negedge clock_in);
    chk("lost_on_time", 32'(signal_lost), 32'd1);
    chk("duty_held_lost", duty_out, exp_duty);
    chk("period_held_lost", period_out, exp_period);
    have_prev = 1'b0;
    repeat (20) @(negedge clock_in);
    send_frame(101, FRAME);
    send_frame(101, FRAME);

    // Input stuck high
    rise_event(3000);
    chk("lost_stuck_high", 32'(signal_lost), 32'd1);
    pwm_in = 1'b0;
    repeat (100) @(negedge clock_in);
    chk("lost_after_fall", 32'(signal_lost), 32'd1);
    have_prev = 1'b0;
    send_frame(101, FRAME);

    // Reset pulse in the middle of a high phase
    rise_event(40);
    reset_n = 1'b0;
    #1;
    chk("midrst_duty", duty_out, 32'd0);
    chk("midrst_period", period_out, 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_oor", 32'(out_of_range), 32'd0);
    chk("midrst_lost", 32'(signal_lost), 32'd1);
    @(negedge clock_in);
    reset_n    = 1'b1;
    exp_duty   = '0;
    exp_period = '0;
    exp_oor    = 1'b0;
    repeat (20) @(negedge clock_in);
    pwm_in = 1'b0;
    repeat (FRAME - 100) @(negedge clock_in);
    have_prev = 1'b1;
    prev_h    = 0;
    prev_p    = 0;
    send_frame(101, FRAME);
    send_frame(101, FRAME);

    // Range boundaries
    send_frame(MIN_HIGH, FRAME);
    send_frame(MAX_HIGH, FRAME);
    send_frame(MIN_HIGH - 1, FRAME);
    send_frame(MAX_HIGH + 1, FRAME);
    rise_event(101);
    pwm_in = 1'b0;
    repeat (20) @(negedge clock_in);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
